// File: rtl/mips32_boot_ctrl_if.sv
// Host/core-facing bundle of the boot sequencer: program stream, imem write port,
// core control bits, register-file read port, dump stream and status flags.
interface mips32_boot_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int REG_AW = 5
);
  logic              start;
  logic              prog_valid;
  logic              prog_ready;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_clear;
  logic              cpu_run;
  logic              cpu_halted;
  logic [REG_AW-1:0] reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [REG_AW-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W:0]   prog_count;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic              load_trunc;

  // master: host, core and memory side; slave: the sequencer
  modport master (
    output start, prog_valid, prog_data, prog_last, cpu_halted, reg_rd_data, dump_ready,
    input  prog_ready, imem_we, imem_addr, imem_wdata, cpu_clear, cpu_run, reg_rd_addr,
           dump_valid, dump_idx, dump_data, prog_count, busy, done, timeout_err, load_trunc
  );

  modport slave (
    input  start, prog_valid, prog_data, prog_last, cpu_halted, reg_rd_data, dump_ready,
    output prog_ready, imem_we, imem_addr, imem_wdata, cpu_clear, cpu_run, reg_rd_addr,
           dump_valid, dump_idx, dump_data, prog_count, busy, done, timeout_err, load_trunc
  );
endinterface

// File: rtl/mips32_boot_ctrl.sv
// Load / run / dump sequencer for the pipelined MIPS32 core: streams a program into imem,
// clears and runs the core until HLT or watchdog, then streams out a register window.
module mips32_boot_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int REG_AW    = 5,
  parameter int DUMP_BASE = 0,
  parameter int NUM_DUMP  = 6,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk1,
  input  logic              rst_n,
  mips32_boot_ctrl_if.slave bus
);

  localparam int                WD_W      = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [REG_AW-1:0] DUMP_LAST = REG_AW'(NUM_DUMP - 1);
  localparam logic [REG_AW-1:0] BASE_IDX  = REG_AW'(DUMP_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_DONE
  } state_e;

  state_e            state_q,       state_d;
  logic [ADDR_W:0]   prog_count_q,  prog_count_d;
  logic [WD_W-1:0]   wdog_q,        wdog_d;
  logic [REG_AW-1:0] dump_cnt_q,    dump_cnt_d;
  logic [REG_AW-1:0] dump_idx_q,    dump_idx_d;
  logic [DATA_W-1:0] dump_data_q,   dump_data_d;
  logic              timeout_err_q, timeout_err_d;
  logic              load_trunc_q,  load_trunc_d;

  logic [REG_AW-1:0] rd_addr;
  assign rd_addr = BASE_IDX + dump_cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      prog_count_q  <= '0;
      wdog_q        <= '0;
      dump_cnt_q    <= '0;
      dump_idx_q    <= '0;
      dump_data_q   <= '0;
      timeout_err_q <= 1'b0;
      load_trunc_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_count_q  <= prog_count_d;
      wdog_q        <= wdog_d;
      dump_cnt_q    <= dump_cnt_d;
      dump_idx_q    <= dump_idx_d;
      dump_data_q   <= dump_data_d;
      timeout_err_q <= timeout_err_d;
      load_trunc_q  <= load_trunc_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    prog_count_d   = prog_count_q;
    wdog_d         = wdog_q;
    dump_cnt_d     = dump_cnt_q;
    dump_idx_d     = dump_idx_q;
    dump_data_d    = dump_data_q;
    timeout_err_d  = timeout_err_q;
    load_trunc_d   = load_trunc_q;
    bus.prog_ready  = 1'b0;
    bus.imem_we     = 1'b0;
    bus.imem_wdata  = '0;
    bus.cpu_clear   = 1'b0;
    bus.cpu_run     = 1'b0;
    bus.reg_rd_addr = '0;
    bus.dump_valid  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d       = S_LOAD;
          prog_count_d  = '0;
          timeout_err_d = 1'b0;
          load_trunc_d  = 1'b0;
        end
      end

      S_LOAD: begin
        bus.prog_ready = 1'b1;
        if (bus.prog_valid) begin
          bus.imem_we    = 1'b1;
          bus.imem_wdata = bus.prog_data;
          prog_count_d   = prog_count_q + 1'b1;
          if (bus.prog_last) begin
            state_d = S_CLEAR;
          end else if (&prog_count_q[ADDR_W-1:0]) begin
            // Last imem slot filled without prog_last: stop rather than wrap.
            load_trunc_d = 1'b1;
            state_d      = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        bus.cpu_clear = 1'b1;
        wdog_d        = '0;
        dump_cnt_d    = '0;
        state_d       = S_RUN;
      end

      S_RUN: begin
        bus.cpu_run = 1'b1;
        wdog_d      = wdog_q + 1'b1;
        if (bus.cpu_halted) begin
          state_d = S_DUMP_RD;
        end else if (wdog_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_DUMP_RD;
        end
      end

      S_DUMP_RD: begin
        bus.reg_rd_addr = rd_addr;
        dump_data_d     = bus.reg_rd_data;
        dump_idx_d      = rd_addr;
        state_d         = S_DUMP_OUT;
      end

      S_DUMP_OUT: begin
        bus.dump_valid = 1'b1;
        if (bus.dump_ready) begin
          if (dump_cnt_q == DUMP_LAST) begin
            state_d = S_DONE;
          end else begin
            dump_cnt_d = dump_cnt_q + 1'b1;
            state_d    = S_DUMP_RD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imem_addr   = prog_count_q[ADDR_W-1:0];
  assign bus.prog_count  = prog_count_q;
  assign bus.dump_idx    = dump_idx_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.load_trunc  = load_trunc_q;
  assign bus.done        = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_mips32_boot_ctrl.sv
// Bench for mips32_boot_ctrl: a behavioural MIPS core stands in for the real one, sessions
// are described in a table and compared against expectations derived from the program text.
module tb_mips32_boot_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int REG_AW = 5;

  logic clk1 = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk1 = ~clk1;

  mips32_boot_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) ifa ();
  mips32_boot_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(3), .REG_AW(REG_AW)) ifb ();

  mips32_boot_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DUMP_BASE(0),
                     .NUM_DUMP(6), .TIMEOUT(256))
    dut (.clk1(clk1), .rst_n(rst_n), .bus(ifa));

  mips32_boot_ctrl #(.DATA_W(DATA_W), .ADDR_W(3), .REG_AW(REG_AW), .DUMP_BASE(0),
                     .NUM_DUMP(6), .TIMEOUT(256))
    dut_small (.clk1(clk1), .rst_n(rst_n), .bus(ifb));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural core: one instruction per enabled cycle ----------------
  logic [31:0] imem [1024];
  logic [31:0] regs [32];
  int          pc;
  int          loaded_hi;
  logic        halted = 1'b0;

  always @(posedge clk1) begin : core_model
    logic [31:0] ins;
    if (ifa.start) loaded_hi <= 0;
    if (ifa.imem_we) begin
      imem[int'(ifa.imem_addr)] <= ifa.imem_wdata;
      loaded_hi <= int'(ifa.imem_addr) + 1;
    end
    if (ifa.cpu_clear) begin
      pc <= 0;
      halted <= 1'b0;
      for (int k = 0; k < 32; k++) regs[k] <= 32'(k);
    end else if (ifa.cpu_run && !halted) begin
      ins = (pc < loaded_hi) ? imem[pc] : 32'h0c00_0000;
      pc <= pc + 1;
      case (ins[31:26])
        6'h00: if (ins[15:11] != 0) regs[ins[15:11]] <= regs[ins[25:21]] + regs[ins[20:16]];
        6'h03: if (ins[15:11] != 0) regs[ins[15:11]] <= regs[ins[25:21]] | regs[ins[20:16]];
        6'h0a: if (ins[20:16] != 0) regs[ins[20:16]] <= regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
        6'h3f: halted <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ifa.cpu_halted  = halted;
  assign ifa.reg_rd_data = regs[ifa.reg_rd_addr];
  assign ifb.cpu_halted  = 1'b1;
  assign ifb.reg_rd_data = 32'(ifb.reg_rd_addr) + 32'd100;

  function automatic logic [31:0] r_type(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // ---------------- monitor on the main instance ----------------
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [4:0]  dmp_idx_q [$];
  logic [31:0] dmp_data_q [$];
  int   clear_cnt, run_cnt, stall2;
  bit   log_en = 1'b0;
  bit   hold_pend;
  logic [31:0] held_data;
  logic [4:0]  held_idx;

  always @(negedge clk1) begin
    if (rst_n && log_en) begin
      if (ifa.imem_we) begin
        wr_addr_q.push_back(32'(ifa.imem_addr));
        wr_data_q.push_back(ifa.imem_wdata);
        check("write only with prog_valid", ifa.prog_valid, 1);
      end
      if (ifa.cpu_clear) clear_cnt++;
      if (ifa.cpu_run) run_cnt++;
      if (hold_pend) begin
        check("dump_valid held while stalled", ifa.dump_valid, 1);
        check("dump_data stable while stalled", ifa.dump_data, held_data);
        check("dump_idx stable while stalled", ifa.dump_idx, held_idx);
      end
      if (ifa.dump_valid && ifa.dump_ready) begin
        dmp_idx_q.push_back(ifa.dump_idx);
        dmp_data_q.push_back(ifa.dump_data);
      end
      if (ifa.dump_valid && !ifa.dump_ready && ifa.dump_idx == 5'd2) stall2++;
      hold_pend = ifa.dump_valid && !ifa.dump_ready;
      held_data = ifa.dump_data;
      held_idx  = ifa.dump_idx;
    end
  end

  // ---------------- session table ----------------
  // vmode: 0 valid always, 1 valid every other cycle, 2 random
  // rmode: 0 ready always, 1 random, 2 stall 3 cycles on idx 2
  typedef struct {
    int               vmode;
    int               rmode;
    bit               use_b;
    int               exp_count;
    bit               exp_tmo;
    int               exp_run;
    logic [5:0][31:0] exp_dump;
  } scen_t;

  scen_t       scen [4];
  logic [31:0] prog_a [$];
  logic [31:0] prog_b [$];

  task automatic run_session(input logic [31:0] prog [$], input int vmode, input int rmode,
                             input int exp_count, input bit exp_tmo, input int exp_run,
                             input logic [5:0][31:0] exp_dump, input string tag);
    int i = 0;
    int cyc = 0;
    int stall = 0;
    bit fin = 1'b0;
    bit beat;
    wr_addr_q.delete(); wr_data_q.delete(); dmp_idx_q.delete(); dmp_data_q.delete();
    clear_cnt = 0; run_cnt = 0; stall2 = 0; hold_pend = 1'b0; log_en = 1'b1;
    @(posedge clk1); #1 ifa.start = 1'b1;
    @(posedge clk1); #1 ifa.start = 1'b0;
    while (!fin) begin
      ifa.prog_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      ifa.prog_data  = prog[i];
      ifa.prog_last  = (i == prog.size() - 1);
      @(negedge clk1);
      beat = ifa.prog_valid && ifa.prog_ready;
      if (!ifa.prog_ready) fin = 1'b1;
      @(posedge clk1); #1;
      if (beat) begin
        if (ifa.prog_last) fin = 1'b1;
        i++;
      end
      cyc++;
      if (cyc > 500) begin
        check({tag, " load finished in budget"}, 0, 1);
        fin = 1'b1;
      end
    end
    ifa.prog_valid = 1'b0;
    ifa.prog_last  = 1'b0;
    fin = 1'b0;
    cyc = 0;
    while (!fin) begin
      if (rmode == 2 && ifa.dump_valid && ifa.dump_idx == 5'd2 && stall < 3) begin
        ifa.dump_ready = 1'b0;
        stall++;
      end else begin
        ifa.dump_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk1);
      if (ifa.done) fin = 1'b1;
      else begin
        @(posedge clk1); #1;
        cyc++;
        if (cyc > 3000) begin
          check({tag, " done reached in budget"}, 0, 1);
          fin = 1'b1;
        end
      end
    end
    ifa.dump_ready = 1'b0;
    log_en = 1'b0;
    check({tag, " prog_count"}, ifa.prog_count, exp_count);
    check({tag, " imem write count"}, wr_addr_q.size(), exp_count);
    for (int k = 0; k < wr_addr_q.size() && k < prog.size(); k++) begin
      check($sformatf("%s imem_addr[%0d]", tag, k), wr_addr_q[k], k);
      check($sformatf("%s imem_wdata[%0d]", tag, k), wr_data_q[k], prog[k]);
    end
    check({tag, " cpu_clear pulses"}, clear_cnt, 1);
    check({tag, " cpu_run cycles"}, run_cnt, exp_run);
    check({tag, " timeout_err"}, ifa.timeout_err, exp_tmo);
    check({tag, " load_trunc"}, ifa.load_trunc, 0);
    check({tag, " done"}, ifa.done, 1);
    check({tag, " busy at end"}, ifa.busy, 0);
    check({tag, " dump transfers"}, dmp_idx_q.size(), 6);
    for (int k = 0; k < dmp_idx_q.size() && k < 6; k++) begin
      check($sformatf("%s dump_idx[%0d]", tag, k), dmp_idx_q[k], k);
      check($sformatf("%s dump_data[%0d]", tag, k), dmp_data_q[k], exp_dump[k]);
    end
    if (rmode == 2) check({tag, " stall cycles on idx 2"}, stall2, 3);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " cpu_run"}, ifa.cpu_run, 0);
    check({tag, " busy"}, ifa.busy, 0);
    check({tag, " prog_ready"}, ifa.prog_ready, 0);
    check({tag, " imem_we"}, ifa.imem_we, 0);
    check({tag, " cpu_clear"}, ifa.cpu_clear, 0);
    check({tag, " dump_valid"}, ifa.dump_valid, 0);
    check({tag, " dump_data"}, ifa.dump_data, 0);
    check({tag, " dump_idx"}, ifa.dump_idx, 0);
    check({tag, " prog_count"}, ifa.prog_count, 0);
    check({tag, " done"}, ifa.done, 0);
    check({tag, " timeout_err"}, ifa.timeout_err, 0);
    check({tag, " load_trunc"}, ifa.load_trunc, 0);
  endtask

  initial begin
    logic [31:0]      prog_r [$];
    logic [5:0][31:0] exp_r;
    int   n, rt, imm, nw, cyc;
    logic rdy8;

    ifa.start = 0; ifa.prog_valid = 0; ifa.prog_data = '0; ifa.prog_last = 0; ifa.dump_ready = 0;
    ifb.start = 0; ifb.prog_valid = 0; ifb.prog_data = '0; ifb.prog_last = 0; ifb.dump_ready = 0;

    prog_a = '{i_type(6'h0a, 0, 1, 10), i_type(6'h0a, 0, 2, 20), i_type(6'h0a, 0, 3, 25),
               r_type(6'h03, 7, 7, 7), r_type(6'h03, 7, 7, 7), r_type(6'h00, 1, 2, 4),
               r_type(6'h03, 7, 7, 7), r_type(6'h00, 4, 3, 5), 32'hfc00_0000};
    for (int k = 0; k < 16; k++) prog_b.push_back(r_type(6'h03, 7, 7, 7));

    scen[0] = '{0, 0, 1'b0, 9, 1'b0, 10, {32'd55, 32'd30, 32'd25, 32'd20, 32'd10, 32'd0}};
    scen[1] = '{1, 0, 1'b0, 9, 1'b0, 10, {32'd55, 32'd30, 32'd25, 32'd20, 32'd10, 32'd0}};
    scen[2] = '{0, 2, 1'b0, 9, 1'b0, 10, {32'd55, 32'd30, 32'd25, 32'd20, 32'd10, 32'd0}};
    scen[3] = '{0, 1, 1'b1, 16, 1'b1, 256, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0}};

    #2 rst_n = 1'b0;
    #1 check_quiet("reset");
    #19 rst_n = 1'b1;

    for (int s = 0; s < 4; s++)
      run_session(scen[s].use_b ? prog_b : prog_a, scen[s].vmode, scen[s].rmode,
                  scen[s].exp_count, scen[s].exp_tmo, scen[s].exp_run, scen[s].exp_dump,
                  $sformatf("scen%0d", s));

    // Random ADDI programs: final register values follow from the last write to each index.
    for (int r = 0; r < 3; r++) begin
      prog_r.delete();
      for (int k = 0; k < 6; k++) exp_r[k] = 32'(k);
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
        rt  = $urandom_range(1, 5);
        imm = $urandom_range(0, 1000);
        prog_r.push_back(i_type(6'h0a, 0, rt, imm));
        exp_r[rt] = 32'(imm);
      end
      prog_r.push_back(32'hfc00_0000);
      run_session(prog_r, 2, 1, n + 1, 1'b0, n + 2, exp_r, $sformatf("rand%0d", r));
    end

    // Truncation on an 8-word memory: 10 words offered, no prog_last.
    @(posedge clk1); #1 ifb.start = 1'b1;
    @(posedge clk1); #1 ifb.start = 1'b0;
    nw = 0;
    rdy8 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ifb.prog_valid = 1'b1;
      ifb.prog_data  = 32'ha000_0000 + 32'(k);
      @(negedge clk1);
      if (k == 8) rdy8 = ifb.prog_ready;
      if (ifb.imem_we) begin
        check("trunc imem_addr", ifb.imem_addr, nw);
        check("trunc imem_wdata", ifb.imem_wdata, 32'ha000_0000 + 32'(nw));
        nw++;
      end
      @(posedge clk1); #1;
    end
    ifb.prog_valid = 1'b0;
    ifb.dump_ready = 1'b1;
    cyc = 0;
    while (!ifb.done && cyc < 200) begin
      @(posedge clk1); #1 cyc++;
    end
    check("trunc done in budget", ifb.done, 1);
    check("trunc write count", nw, 8);
    check("trunc prog_ready low after 8th beat", rdy8, 0);
    check("trunc load_trunc", ifb.load_trunc, 1);
    check("trunc prog_count", ifb.prog_count, 8);
    check("trunc timeout_err", ifb.timeout_err, 0);
    ifb.dump_ready = 1'b0;

    // Asynchronous reset in the middle of RUN, then a clean repeat of the first session.
    @(posedge clk1); #1 ifa.start = 1'b1;
    @(posedge clk1); #1 ifa.start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      ifa.prog_valid = 1'b1;
      ifa.prog_data  = prog_a[k];
      ifa.prog_last  = (k == 8);
      @(posedge clk1); #1;
    end
    ifa.prog_valid = 1'b0;
    ifa.prog_last  = 1'b0;
    cyc = 0;
    while (!ifa.cpu_run && cyc < 20) begin
      @(posedge clk1); #1 cyc++;
    end
    @(posedge clk1); #1;
    check("pre-reset cpu_run", ifa.cpu_run, 1);
    check("pre-reset prog_count", ifa.prog_count, 9);
    #2 rst_n = 1'b0;
    #1 check_quiet("mid-run reset");
    #8 rst_n = 1'b1;
    run_session(prog_a, scen[0].vmode, scen[0].rmode, scen[0].exp_count, scen[0].exp_tmo,
                scen[0].exp_run, scen[0].exp_dump, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_boot_ctrl.md
Name: mips32_boot_ctrl

Overview:
- Synthesisable boot/run/dump sequencer for the pipelined MIPS32 core. It generalises the program-load / run / register-dump flow of the core bench into RTL.
- It streams a program into instruction memory over a valid/ready port, clears the core's PC/HALTED/TAKEN_BRANCH state, and runs the core until HLT or a watchdog timeout.
- It then streams out a configurable window of register-file contents over a second valid/ready port.
- It sits between a host/loader interface and the core's memory, register-file read port and control bits.

Parameters:
- DATA_W, 32, instruction and register data width
- ADDR_W, 10, instruction memory address width; depth = 2**ADDR_W words
- REG_AW, 5, register-file address width
- DUMP_BASE, 0, first register index dumped
- NUM_DUMP, 6, number of registers dumped (1..2**REG_AW - DUMP_BASE)
- TIMEOUT, 256, maximum RUN cycles before watchdog abort (>=2)

Ports:
- clk1 in 1 single system clock, rising edge
- rst_n in 1 asynchronous active-low reset
- start in 1 single-cycle request to begin a load/run/dump session
- prog_valid in 1 program word valid
- prog_ready out 1 sequencer accepts a program word
- prog_data in DATA_W program word
- prog_last in 1 marks the final program word
- imem_we out 1 instruction memory write strobe
- imem_addr out ADDR_W instruction memory write address
- imem_wdata out DATA_W instruction memory write data
- cpu_clear out 1 one-cycle clear of core PC, HALTED and TAKEN_BRANCH
- cpu_run out 1 core enable; core stalls when low
- cpu_halted in 1 core HALTED flag
- reg_rd_addr out REG_AW register-file read address (combinational read)
- reg_rd_data in DATA_W register-file read data
- dump_valid out 1 dump word valid
- dump_ready in 1 consumer accepts dump word
- dump_idx out REG_AW register index of the current dump word
- dump_data out DATA_W register value
- prog_count out ADDR_W+1 words written in this session
- busy out 1 high in every state except IDLE and DONE
- done out 1 session complete
- timeout_err out 1 watchdog fired in this session
- load_trunc out 1 program exceeded memory depth without prog_last

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; counters 0. Outputs take their reset values immediately, including mid-session. cpu_run=0 while in reset.
- States: IDLE, LOAD, CLEAR, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE and DONE: start -> LOAD. Entering LOAD clears prog_count, done, timeout_err and load_trunc. start is ignored in all other states.
- LOAD:
  - prog_ready=1.
  - On a beat (prog_valid & prog_ready), in the same cycle: imem_we=1, imem_addr=prog_count[ADDR_W-1:0], imem_wdata=prog_data; prog_count increments at the clock edge.
  - imem_we=0 in all non-beat cycles.
  - Beat with prog_last -> CLEAR.
  - Beat at address 2**ADDR_W-1 without prog_last -> set load_trunc, go to CLEAR. Addresses never wrap.
- CLEAR: cpu_clear=1 for exactly one cycle, prog_ready=0, then RUN.
- RUN:
  - cpu_run=1; the watchdog counter starts at 0 and increments each RUN cycle.
  - cpu_halted=1 -> DUMP_RD; cpu_run drops in the same edge.
  - If the watchdog equals TIMEOUT-1 and cpu_halted=0 -> set timeout_err, then DUMP_RD.
  - If halt and timeout occur in the same cycle, halt wins: timeout_err stays 0.
- DUMP_RD:
  - reg_rd_addr = DUMP_BASE + dump counter.
  - At the edge, dump_data <= reg_rd_data and dump_idx <= reg_rd_addr; go to DUMP_OUT.
- DUMP_OUT:
  - dump_valid=1; dump_data and dump_idx are held stable while dump_ready=0.
  - On handshake: if counter==NUM_DUMP-1 -> DONE, else counter++ -> DUMP_RD.
  - Throughput: 1 word per 2 cycles when dump_ready is held high.
- DONE: done=1 and all flags held until the next start.
- The dump always runs, including after a timeout or truncation.

Test Plan:
1. Load 9 words (ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; 2×OR R7 dummy; ADD R4,R1,R2; OR R7 dummy; ADD R5,R4,R3; HLT) with prog_last on word 9, against the core model with Reg[k]=k preloaded:
   - imem writes go to addresses 0..8 and prog_count=9.
   - cpu_clear pulses once.
   - The dump yields idx/data 0/0, 1/10, 2/20, 3/25, 4/30, 5/55, then done=1 and timeout_err=0.
2. prog_valid toggling every other cycle during load -> exactly 9 imem_we pulses at contiguous addresses 0..8; no write occurs in valid-low cycles.
3. dump_ready held low for 3 cycles on idx 2 -> dump_valid stays high and dump_data=20 is stable throughout; exactly one transfer occurs for idx 2.
4. Core never halts (program without HLT), TIMEOUT=256 -> cpu_run is high for exactly 256 cycles, timeout_err=1, the dump of 6 registers still completes, and done=1.
5. ADDR_W=3, 10 words sent with no prog_last -> 8 writes at addresses 0..7, prog_ready low after the 8th beat, load_trunc=1, prog_count=8.
6. rst_n asserted mid-RUN -> cpu_run, busy and all other outputs go to 0 asynchronously. After release, a new start repeats scenario 1 with identical results.
